// File: rtl/k_self_trigger_pkg.sv
// k_self_trigger_pkg: shared state encoding, widths and helpers for the self-trigger slice
package k_self_trigger_pkg;
  typedef enum logic [1:0] {ARMED, QUALIFY, ACTIVE, HOLDOFF} state_t;
  localparam int SAMPLE_W = 16;
  localparam int TRIG_CNT_W = 32;
  function automatic logic signed [SAMPLE_W-1:0] smax(input logic signed [SAMPLE_W-1:0] a, input logic signed [SAMPLE_W-1:0] b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/k_holdoff_counter.sv
// k_holdoff_counter: loadable down-counter; done flags the sample that would take it to zero
module k_holdoff_counter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         load,
  input  logic [W-1:0] holdoff,
  output logic         done
);
  logic [W-1:0] count;
  assign done = count == W'(1);
  // load wins over counting; counting stops at zero
  always_ff @(posedge clk or negedge reset)
    if (!reset) count <= '0;
    else if (load) count <= holdoff;
    else if (enable && count != '0) count <= count - W'(1);
endmodule

// File: rtl/k_self_trigger.sv
// k_self_trigger: consecutive-sample threshold trigger with hold-off; peak capture built only with K_SELF_TRIGGER_PEAK_EN
module k_self_trigger
  import k_self_trigger_pkg::*;
#(
  parameter int CONSEC_N  = 2,
  parameter int HOLDOFF_W = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic signed [SAMPLE_W-1:0]   x,
  input  logic signed [SAMPLE_W-1:0]   threshold,
  input  logic [HOLDOFF_W-1:0]         holdoff,
  output logic                         trigger,
  output logic                         busy,
  output logic signed [SAMPLE_W-1:0]   peak,
  output logic                         peak_valid,
  output logic [TRIG_CNT_W-1:0]        trig_count
);
  localparam logic [3:0] CN = 4'(CONSEC_N);
  state_t state;
  logic [3:0] cnt;
  logic above, pulse_end, hold_done;
  assign above = x > threshold;
  assign pulse_end = enable && state == ACTIVE && !above;
  k_holdoff_counter #(.W(HOLDOFF_W)) u_hold (
    .clk(clk),
    .reset(reset),
    .enable(enable && state == HOLDOFF),
    .load(pulse_end),
    .holdoff(holdoff),
    .done(hold_done)
  );
  // control FSM; trigger is a single-clock pulse even if enable drops right after firing
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= ARMED;
      cnt <= '0;
      trigger <= 1'b0;
      busy <= 1'b0;
      trig_count <= '0;
    end else begin
      trigger <= 1'b0;
      if (enable)
        case (state)
          ARMED: if (above) begin
            busy <= 1'b1;
            if (CN == 4'd1) begin
              state <= ACTIVE;
              trigger <= 1'b1;
              trig_count <= trig_count + 1'b1;
            end else begin
              state <= QUALIFY;
              cnt <= 4'd1;
            end
          end
          QUALIFY: if (!above) begin
            state <= ARMED;
            cnt <= '0;
            busy <= 1'b0;
          end else if (cnt + 4'd1 == CN) begin
            state <= ACTIVE;
            cnt <= '0;
            trigger <= 1'b1;
            trig_count <= trig_count + 1'b1;
          end else cnt <= cnt + 4'd1;
          ACTIVE: if (!above) begin
            state <= holdoff == '0 ? ARMED : HOLDOFF;
            busy <= holdoff != '0;
          end
          HOLDOFF: if (hold_done) begin
            state <= ARMED;
            busy <= 1'b0;
          end
          default: state <= ARMED;
        endcase
    end
`ifdef K_SELF_TRIGGER_PEAK_EN
  logic signed [SAMPLE_W-1:0] run_max;
  // running maximum from the first crossing, published when the pulse ends
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      run_max <= '0;
      peak <= '0;
      peak_valid <= 1'b0;
    end else begin
      peak_valid <= pulse_end;
      if (enable && above && state == ARMED) run_max <= x;
      else if (enable && above && (state == QUALIFY || state == ACTIVE)) run_max <= smax(run_max, x);
      if (pulse_end) peak <= run_max;
    end
`else
  assign peak = '0;
  assign peak_valid = 1'b0;
`endif
endmodule

// File: tb/tb_k_self_trigger.sv
// tb_k_self_trigger: table-driven directed checks plus reset and counter-wrap sequences
module tb_k_self_trigger;
  logic clk = 1'b0, reset = 1'b0, enable = 1'b0;
  logic signed [15:0] x = '0, threshold = 16'sd100, peak;
  logic [9:0] holdoff = '0;
  logic trigger, busy, peak_valid;
  logic [31:0] trig_count;
  int checks = 0, errors = 0;
`ifdef K_SELF_TRIGGER_PEAK_EN
  localparam bit PK = 1'b1;
`else
  localparam bit PK = 1'b0;
`endif
  typedef struct {
    logic en;
    logic signed [15:0] x, thr;
    logic [9:0] hold;
    logic trig, busy;
    logic [31:0] cnt;
    logic signed [15:0] pk;
    logic pv;
  } vec_t;
  vec_t vq[$];
  k_self_trigger dut (
    .clk(clk), .reset(reset), .enable(enable), .x(x), .threshold(threshold),
    .holdoff(holdoff), .trigger(trigger), .busy(busy), .peak(peak),
    .peak_valid(peak_valid), .trig_count(trig_count)
  );
  always #5 clk = ~clk;
  task automatic add(input logic en, input int xv, input int thr, input int hold, input logic trig, input logic bs, input int cnt, input int pk, input logic pv);
    vec_t v;
    v.en = en; v.x = 16'(xv); v.thr = 16'(thr); v.hold = 10'(hold);
    v.trig = trig; v.busy = bs; v.cnt = 32'(cnt); v.pk = 16'(pk); v.pv = pv;
    vq.push_back(v);
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic trig, input logic bs, input logic [31:0] cnt, input logic signed [15:0] pk, input logic pv);
    chk({tag, " trigger"}, {31'b0, trigger}, {31'b0, trig});
    chk({tag, " busy"}, {31'b0, busy}, {31'b0, bs});
    chk({tag, " trig_count"}, trig_count, cnt);
    chk({tag, " peak"}, {16'b0, peak}, PK ? {16'b0, pk} : 32'b0);
    chk({tag, " peak_valid"}, {31'b0, peak_valid}, {31'b0, PK & pv});
  endtask
  task automatic step(input logic en, input int xv);
    enable = en; x = 16'(xv);
    @(posedge clk); #1;
  endtask
  initial begin
    // basic fire, no hold-off
    add(1, 50, 100, 0, 0, 0, 0, 0, 0);
    add(1, 150, 100, 0, 0, 1, 0, 0, 0);
    add(1, 160, 100, 0, 1, 1, 1, 0, 0);
    add(1, 80, 100, 0, 0, 0, 1, 160, 1);
    // glitch rejection
    add(1, 150, 100, 0, 0, 1, 1, 160, 0);
    add(1, 90, 100, 0, 0, 0, 1, 160, 0);
    add(1, 150, 100, 0, 0, 1, 1, 160, 0);
    add(1, 90, 100, 0, 0, 0, 1, 160, 0);
    // equality is not a crossing
    add(1, 100, 100, 0, 0, 0, 1, 160, 0);
    add(1, 100, 100, 0, 0, 0, 1, 160, 0);
    // hold-off of 3, crossings ignored meanwhile
    add(1, 150, 100, 3, 0, 1, 1, 160, 0);
    add(1, 150, 100, 3, 1, 1, 2, 160, 0);
    add(1, 50, 100, 3, 0, 1, 2, 150, 1);
    add(1, 150, 100, 3, 0, 1, 2, 150, 0);
    add(1, 150, 100, 3, 0, 1, 2, 150, 0);
    add(1, 150, 100, 3, 0, 0, 2, 150, 0);
    add(1, 150, 100, 3, 0, 1, 2, 150, 0);
    add(1, 150, 100, 3, 1, 1, 3, 150, 0);
    add(1, 50, 100, 3, 0, 1, 3, 150, 1);
    // hold-off freezes while enable is low
    add(0, 150, 100, 3, 0, 1, 3, 150, 0);
    add(1, 150, 100, 3, 0, 1, 3, 150, 0);
    add(1, 150, 100, 3, 0, 1, 3, 150, 0);
    add(1, 150, 100, 3, 0, 0, 3, 150, 0);
    add(1, 50, 100, 0, 0, 0, 3, 150, 0);
    // enable gating mid-QUALIFY
    add(1, 150, 100, 0, 0, 1, 3, 150, 0);
    for (int i = 0; i < 5; i++) add(0, 500, 100, 0, 0, 1, 3, 150, 0);
    add(1, 150, 100, 0, 1, 1, 4, 150, 0);
    add(1, 50, 100, 0, 0, 0, 4, 150, 1);
    // peak tracked through ACTIVE
    add(1, 120, 100, 0, 0, 1, 4, 150, 0);
    add(1, 300, 100, 0, 1, 1, 5, 150, 0);
    add(1, 200, 100, 0, 0, 1, 5, 150, 0);
    add(1, 400, 100, 0, 0, 1, 5, 150, 0);
    add(1, 100, 100, 0, 0, 0, 5, 400, 1);
    // signed boundary
    add(1, -32767, -32768, 0, 0, 1, 5, 400, 0);
    add(1, -32767, -32768, 0, 1, 1, 6, 400, 0);
    add(1, -32768, -32768, 0, 0, 0, 6, -32767, 1);
    // live threshold change aborts qualification
    add(1, 0, -10, 0, 0, 1, 6, -32767, 0);
    add(1, 0, 10, 0, 0, 0, 6, -32767, 0);
    #2;
    chk_all("reset", 0, 0, 0, 0, 0);
    @(negedge clk); reset = 1'b1;
    foreach (vq[i]) begin
      threshold = vq[i].thr; holdoff = vq[i].hold;
      step(vq[i].en, vq[i].x);
      chk_all($sformatf("vec%0d", i), vq[i].trig, vq[i].busy, vq[i].cnt, vq[i].pk, vq[i].pv);
    end
    // asynchronous reset while ACTIVE
    threshold = 16'sd100; holdoff = '0;
    step(1, 300);
    step(1, 300);
    chk_all("pre_reset_fire", 1, 1, 7, -32767, 0);
    step(1, 300);
    #3 reset = 1'b0;
    #1 chk_all("async_reset", 0, 0, 0, 0, 0);
    @(negedge clk); reset = 1'b1;
    step(1, 300);
    chk_all("post_reset_q", 0, 1, 0, 0, 0);
    step(1, 300);
    chk_all("post_reset_fire", 1, 1, 1, 0, 0);
    step(1, 50);
    chk_all("post_reset_end", 0, 0, 1, 300, 1);
    // trigger counter wraps
    @(negedge clk); force dut.trig_count = 32'hFFFF_FFFF;
    @(negedge clk); release dut.trig_count;
    #1 chk("preload", trig_count, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    step(1, 150);
    step(1, 150);
    chk_all("wrap", 1, 1, 0, 300, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/k_self_trigger.md
# k_self_trigger

Threshold self-trigger stage directly downstream of the pedestal-recovery high-pass filter chain. It consumes the filter's signed 16-bit output and qualifies threshold crossings over a programmable number of consecutive samples. On qualification it emits a one-cycle trigger, then tracks the pulse peak until the signal falls back, and finally enforces a programmable hold-off before re-arming.

## Interface
- `CONSEC_N`, default 2: consecutive enabled samples strictly above `threshold` required to fire (legal 1..15).
- `HOLDOFF_W`, default 10: width of the `holdoff` port and of the hold-off counter.
- `clk`  in  1  sample clock, shared with the filter chain.
- `reset`  in  1  asynchronous, active-low reset; one clock domain only.
- `enable`  in  1  sample qualifier, same signal that drives the filter. When low, all state, counters and registers freeze.
- `x`  in  16  signed filtered sample from the high-pass filter output.
- `threshold`  in  16  signed trigger level, compared live on every enabled sample.
- `holdoff`  in  HOLDOFF_W  number of enabled samples to wait after pulse end; latched on entry to HOLDOFF.
- `trigger`  out  1  one-cycle pulse marking qualification.
- `busy`  out  1  high whenever the state is not ARMED.
- `peak`  out  16  signed maximum sample of the last pulse; held until the next update.
- `peak_valid`  out  1  one-cycle pulse asserted when `peak` updates.
- `trig_count`  out  32  number of triggers since reset; wraps from 0xFFFFFFFF to 0.

## Operation
- Comparison: `x > threshold`, signed, strict. Equality counts as below.
- All transitions occur only on cycles with `enable`=1. With `enable`=0, state, `cnt`, peak register and hold-off counter hold.
- ARMED → QUALIFY when `x` > thr, with `cnt`=1. If `CONSEC_N`=1, go straight to ACTIVE and fire.
- QUALIFY: on `x` > thr, `cnt`++. When `cnt` reaches `CONSEC_N`, fire and go to ACTIVE. On `x` ≤ thr, `cnt`=0 and return to ARMED with no trigger.
- Fire: `trigger`=1 for exactly one cycle; `trig_count`++.
- Peak tracking: the running maximum starts with the first above-threshold sample in QUALIFY and continues through ACTIVE.
- ACTIVE: on `x` ≤ thr, load `peak` with the running max, pulse `peak_valid`, and latch `holdoff`.
  - If `holdoff` = 0, go to ARMED.
  - Otherwise go to HOLDOFF.
- HOLDOFF: decrement the counter on each enabled sample. When it would reach 0, go to ARMED. Threshold crossings during HOLDOFF are ignored, with no trigger and no count.
- Changes to `threshold` take effect on the next enabled sample in any state.

## Timing
- All outputs are registered, with 1-cycle latency from the deciding sample edge. For example, with `CONSEC_N`=2, `trigger` is high in the cycle after the 2nd above-threshold sample is clocked in.
- `peak_valid` is high in the cycle after the first sample ≤ thr in ACTIVE. `busy` drops in the same cycle as the transition to ARMED.
- With `holdoff`=H (H>0), re-arm occurs H enabled samples after the pulse-end sample.
- Reset (async assert, any state, including mid-pulse): state ARMED, `trigger`=0, `busy`=0, `peak`=0, `peak_valid`=0, `trig_count`=0, `cnt`=0, hold-off counter 0. Deassertion is synchronised externally.
- `trigger` and `peak_valid` never assert in the same cycle, because ACTIVE needs at least one cycle.

## Configuration
- `K_SELF_TRIGGER_PEAK_EN` defined: peak tracking, `peak` and `peak_valid` are implemented as described.
- Undefined: no peak datapath. `peak` is tied to 0 and `peak_valid` to 0. The FSM, `trigger`, `busy`, hold-off and `trig_count` are unchanged.

## Structure
- Package `k_self_trigger_pkg`:
  - state typedef: ARMED, QUALIFY, ACTIVE, HOLDOFF.
  - `SAMPLE_W`=16.
  - `TRIG_CNT_W`=32.
- Sub-module `k_holdoff_counter`: loadable down-counter with `enable`, load value `holdoff`, and a `done` output.

## Test plan
- **Basic fire:** thr=100, `CONSEC_N`=2, x=50,150,160,80 with `enable`=1 → `trigger` one cycle after the 160 sample; `peak`=160 and `peak_valid` one cycle after the 80 sample; `trig_count`=1.
- **Glitch rejection:** x=150,90,150,90 → no trigger; `busy` pulses, then returns to 0; `trig_count`=0.
- **Hold-off:** `holdoff`=3, pulse 150,150,50, then 150,150 immediately → second crossing ignored until 3 enabled samples have elapsed; after re-arm, 150,150 fires again and `trig_count`=2.
- **Enable gating:** hold `enable`=0 for 5 cycles mid-QUALIFY with x=500 → no trigger, state held; resume with `enable`=1 and x=150 → fire.
- **Reset mid-ACTIVE:** assert `reset`=0 while x=300 → all outputs 0 immediately, asynchronously. After release with x=300, two samples → trigger; `trig_count`=1.
- **Wrap and boundaries:** preload the count near 0xFFFFFFFF (force) and fire → wraps to 0. x=thr exactly → no crossing. Signed boundary: thr=-32768, x=-32767 → counts as above threshold.
